// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: instruction memory read port,
// decode-side valid/stall stream and branch redirect.
interface instruction_fetch_unit_if;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        fetch_error;

    modport master (
        output imem_address,
        input  imem_instruction,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        output if_pc,
        output if_instruction,
        output fetch_error
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        input  if_pc,
        input  if_instruction,
        input  fetch_error
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch over a 1-cycle registered memory,
// with stall hold buffer, redirect and sticky fault detection.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128
) (
    input logic                       clk,
    input logic                       resetn,
    instruction_fetch_unit_if.master  bus
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        STALL,
        ERROR
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic        resp_valid;
    logic [31:0] hold_instr;

    logic fetch_bad;
    logic redir_bad;

    assign fetch_bad = (fetch_pc[1:0] != 2'b00)
                     || (fetch_pc > LAST_PC);
    assign redir_bad = (bus.redirect_pc[1:0] != 2'b00)
                     || (bus.redirect_pc > LAST_PC);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= BOOT;
            fetch_pc   <= RESET_PC;
            resp_pc    <= 32'h0;
            resp_valid <= 1'b0;
            hold_instr <= 32'h0;
        end else if (state != ERROR) begin
            if (bus.redirect_valid) begin
                resp_valid <= 1'b0;
                if (redir_bad) begin
                    state <= ERROR;
                end else begin
                    state    <= RUN;
                    fetch_pc <= bus.redirect_pc;
                end
            end else if (state == STALL && bus.stall) begin
                state <= STALL;
            end else if (state == RUN && bus.stall
                         && resp_valid) begin
                // memory re-reads next address, so park the word
                hold_instr <= bus.imem_instruction;
                state      <= STALL;
            end else if (fetch_bad) begin
                state      <= ERROR;
                resp_valid <= 1'b0;
            end else begin
                state      <= RUN;
                resp_pc    <= fetch_pc;
                resp_valid <= 1'b1;
                fetch_pc   <= fetch_pc + 32'd4;
            end
        end
    end

    assign bus.imem_address = fetch_pc;
    assign bus.if_valid     = resp_valid && (state != ERROR);
    assign bus.if_pc        = resp_pc;
    assign bus.fetch_error  = (state == ERROR);

    always_comb begin
        bus.if_instruction = 32'h0;
        if (resp_valid) begin
            if (state == STALL)
                bus.if_instruction = hold_instr;
            else
                bus.if_instruction = bus.imem_instruction;
        end
    end

endmodule
